// File: rtl/vader_pkg.sv
// Shared types and constants for the brute-force candidate generator.
// The digit constants are only used when BRUTE_GEN_DIGITS_EN is defined.
package vader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int         NSYM_ALPHA  = 26;
  localparam int         NSYM_DIGIT  = 10;
  localparam logic [7:0] ASCII_ALPHA = 8'h61;
  localparam logic [7:0] ASCII_DIGIT = 8'h30;
  localparam int         CNT_W       = 32;
  localparam int         IDX_W       = 6;

endpackage

// File: rtl/brute_sym_map.sv
// Combinational symbol index to ASCII mapping for one candidate position.
// The digit range exists only when BRUTE_GEN_DIGITS_EN is defined.
import vader_pkg::*;

module brute_sym_map (
  input  logic [IDX_W-1:0] idx_i,
  output logic [7:0]       ascii_o
);

  // Map one symbol index to its ASCII code; unused indices give 0x00.
  always_comb begin
    ascii_o = 8'h00;
    if (idx_i < IDX_W'(NSYM_ALPHA)) begin
      ascii_o = ASCII_ALPHA + {2'b00, idx_i};
    end
`ifdef BRUTE_GEN_DIGITS_EN
    else if (idx_i < IDX_W'(NSYM_ALPHA + NSYM_DIGIT)) begin
      ascii_o = ASCII_DIGIT + {2'b00, idx_i - IDX_W'(NSYM_ALPHA)};
    end
`endif
    else begin
      ascii_o = 8'h00;
    end
  end

endmodule

// File: rtl/brute_gen.sv
// Odometer-style candidate generator with valid/ready output and run control.
// Define BRUTE_GEN_DIGITS_EN to extend the alphabet with '0'..'9'.
import vader_pkg::*;

module brute_gen #(
  parameter int          MAX_LEN       = 4,
  parameter logic [31:0] ATTEMPT_LIMIT = 32'd100
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  output logic                 cand_valid,
  input  logic                 cand_ready,
  output logic [8*MAX_LEN-1:0] cand_data,
  output logic [3:0]           cand_len,
  output logic [31:0]          cand_idx,
  output logic                 busy,
  output logic                 done,
  output logic                 exhausted,
  output logic                 limit_hit
);

`ifdef BRUTE_GEN_DIGITS_EN
  localparam int NSYM = NSYM_ALPHA + NSYM_DIGIT;
`else
  localparam int NSYM = NSYM_ALPHA;
`endif
  localparam logic [IDX_W-1:0] SYM_MAX = IDX_W'(NSYM - 1);
  localparam logic [3:0]       LEN_MAX = 4'(MAX_LEN);

  state_e           state_q;
  logic [IDX_W-1:0] idx_q [MAX_LEN];
  logic [IDX_W-1:0] idx_d [MAX_LEN];
  logic [3:0]       len_q, len_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             valid_q, busy_q, done_q, exh_q, lim_q;
  logic             wrap_s, xfer_s, exh_s, lim_s;

  // Next odometer value; wrap_s means every active position rolled over.
  always_comb begin : odo
    logic carry;
    carry = 1'b1;
    for (int p = 0; p < MAX_LEN; p++) begin
      idx_d[p] = idx_q[p];
      if (carry && (4'(p) < len_q)) begin
        if (idx_q[p] == SYM_MAX) begin
          idx_d[p] = '0;
        end else begin
          idx_d[p] = idx_q[p] + 6'd1;
          carry    = 1'b0;
        end
      end else begin
        idx_d[p] = idx_q[p];
      end
    end
    wrap_s = carry;
    len_d  = wrap_s ? (len_q + 4'd1) : len_q;
  end

  assign xfer_s = valid_q & cand_ready;
  assign cnt_d  = cnt_q + 32'd1;
  assign exh_s  = wrap_s && (len_q == LEN_MAX);
  assign lim_s  = (ATTEMPT_LIMIT != 32'd0) && (cnt_d == ATTEMPT_LIMIT);

  // Run-control FSM; all outputs except the character decode are registered here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      valid_q <= 1'b0;
      len_q   <= 4'd0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      exh_q   <= 1'b0;
      lim_q   <= 1'b0;
      for (int p = 0; p < MAX_LEN; p++) idx_q[p] <= '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_q <= ST_RUN;
            valid_q <= 1'b1;
            len_q   <= 4'd1;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            exh_q   <= 1'b0;
            lim_q   <= 1'b0;
            for (int p = 0; p < MAX_LEN; p++) idx_q[p] <= '0;
          end
        end
        ST_RUN: begin
          if (xfer_s) begin
            cnt_q <= cnt_d;
            // The final candidate stays on the bus rather than overflowing the length.
            if (!exh_s) begin
              idx_q <= idx_d;
              len_q <= len_d;
            end
          end
          if ((xfer_s && (exh_s || lim_s)) || abort) begin
            state_q <= ST_DONE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            exh_q   <= xfer_s && exh_s;
            lim_q   <= xfer_s && lim_s;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < MAX_LEN; g++) begin : g_pos
    logic [7:0] sym_s;
    brute_sym_map u_map (
      .idx_i   (idx_q[g]),
      .ascii_o (sym_s)
    );
    assign cand_data[8*g +: 8] = (4'(g) < len_q) ? sym_s : 8'h00;
  end

  assign cand_valid = valid_q;
  assign cand_len   = len_q;
  assign cand_idx   = cnt_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign exhausted  = exh_q;
  assign limit_hit  = lim_q;

endmodule

// File: doc/brute_gen.md
BRUTE_GEN -- requirements
Module: brute_gen

Interface
REQ-001 Parameter MAX_LEN, default 4, maximum candidate length in characters (1..8).
REQ-002 Parameter ATTEMPT_LIMIT, default 100, 32-bit cap on candidates issued per run.
REQ-003 clk  input  1  system clock; the block uses this single clock.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  single-cycle pulse; begins a run from IDLE or DONE.
REQ-006 abort  input  1  stop request from the downstream comparator (match found).
REQ-007 cand_valid  output  1  candidate on cand_data/cand_len is valid.
REQ-008 cand_ready  input  1  downstream accepts the candidate; a transfer is cand_valid && cand_ready.
REQ-009 cand_data  output  8*MAX_LEN  ASCII candidate; char 0 is at [7:0]; bytes at or above cand_len are 0x00.
REQ-010 cand_len  output  4  current candidate length.
REQ-011 cand_idx  output  32  count of completed transfers in this run.
REQ-012 busy / done / exhausted / limit_hit  output  1 each  run active / run ended / keyspace ended / attempt cap reached.

Function
REQ-013 The FSM SHALL have three states:
- IDLE -> RUN on start.
- RUN -> DONE on exhaustion, limit, or abort.
- DONE -> RUN on start.
REQ-014 On entry to RUN, cand_len=1, all symbol indices=0, cand_idx=0, and flags are cleared; cand_valid SHALL rise on the cycle after start.
REQ-015 Symbol map:
- indices 0..25 -> 0x61..0x7A ('a'..'z').
- indices 26..35 -> 0x30..0x39 ('0'..'9'), only when the digits feature is enabled.
REQ-016 Odometer:
- Each transfer increments position 0; a wrap at NSYM-1 resets it to 0 and carries into the next position.
- A carry out of position cand_len-1 increments cand_len and zeroes all indices.
REQ-017 The block SHALL sustain one candidate per cycle while cand_ready=1; the next candidate is presented on the cycle after a transfer.
REQ-018 While cand_valid=1 and cand_ready=0, cand_data, cand_len and cand_idx SHALL hold stable.
REQ-019 A transfer of the all-max candidate at cand_len=MAX_LEN SHALL set exhausted and enter DONE, with cand_valid=0 on the next cycle.
REQ-020 A transfer that makes cand_idx equal ATTEMPT_LIMIT SHALL set limit_hit and enter DONE; if exhaustion happens on the same transfer, both flags SHALL be set.
REQ-021 abort in RUN SHALL enter DONE on the next cycle.
- A transfer in the same cycle as abort is still counted.
- exhausted and limit_hit are set only if that transfer itself causes them.
REQ-022 start while in RUN and abort while not in RUN SHALL be ignored.
REQ-023 busy=1 exactly in RUN; done=1 exactly in DONE; the flags hold until the next start or reset.
REQ-024 ATTEMPT_LIMIT=0 SHALL be treated as unlimited.

Reset
REQ-025 reset SHALL take priority over all inputs and force:
- IDLE;
- cand_valid=0, cand_data=0, cand_len=0, cand_idx=0;
- busy=done=exhausted=limit_hit=0.
REQ-026 reset asserted mid-run SHALL abandon the run with no further transfers; the first cand_valid after reset requires a new start.

Configuration
REQ-027 With macro BRUTE_GEN_DIGITS_EN defined, NSYM=36 (lowercase plus digits); without it, NSYM=26 (lowercase only) and the digit mapping logic SHALL be absent.

Structure
REQ-028 The shared package vader_pkg SHALL hold:
- the FSM state enumeration;
- NSYM_ALPHA=26 and NSYM_DIGIT=10;
- the ASCII bases 0x61 and 0x30;
- the 32-bit counter width.
REQ-029 Sub-module brute_sym_map SHALL perform the combinational index-to-ASCII mapping; brute_gen SHALL instantiate one per position.

Verification
REQ-030 Enumeration, MAX_LEN=2, digits off, limit=0, ready=1:
- first 26 candidates are 'a'..'z';
- 27th is 0x6161 with len 2, 28th is 0x6162;
- 702nd is 0x7A7A, after which exhausted=1 and done=1.
REQ-031 Attempt limit, ATTEMPT_LIMIT=5: candidates are 'a'..'e', then cand_idx=5, limit_hit=1, exhausted=0, cand_valid=0.
REQ-032 Backpressure: drop cand_ready for 3 cycles while 'c' is presented -> 'c' and cand_idx=2 stay stable; 'd' appears on the cycle after the transfer of 'c'.
REQ-033 Abort: pulse abort together with the transfer of 'h' -> cand_idx=8, done=1, no limit or exhaustion flags; a later start restarts at 'a'.
REQ-034 Digits feature, BRUTE_GEN_DIGITS_EN defined:
- 27th candidate is 0x30 ('0');
- 36th is 0x39 ('9');
- 37th is 0x6161 with len 2.
REQ-035 Reset mid-run: assert reset at cand_idx=10 -> all outputs are 0 in the next cycle; a subsequent start produces 'a' again.
